// File: rtl/baccarat_round_ctrl_if.sv
// Signal bundle between the round controller and the card datapath / board I/O.
interface baccarat_round_ctrl_if #(
  parameter int unsigned TALLY_W = 8
);
  logic               start;
  logic [3:0]         pscore;
  logic [3:0]         dscore;
  logic [3:0]         pcard3;
  logic               load_pcard1;
  logic               load_pcard2;
  logic               load_pcard3;
  logic               load_dcard1;
  logic               load_dcard2;
  logic               load_dcard3;
  logic               player_win_light;
  logic               dealer_win_light;
  logic               busy;
  logic               done;
  logic [TALLY_W-1:0] player_wins;
  logic [TALLY_W-1:0] dealer_wins;
  logic [TALLY_W-1:0] ties;

  modport master (
    input  start, pscore, dscore, pcard3,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output player_win_light, dealer_win_light, busy, done,
    output player_wins, dealer_wins, ties
  );

  modport slave (
    output start, pscore, dscore, pcard3,
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  player_win_light, dealer_win_light, busy, done,
    input  player_wins, dealer_wins, ties
  );
endinterface

// File: rtl/baccarat_round_ctrl.sv
// Punto-banco round sequencer: deals cards, applies third-card rules,
// latches result lights and keeps saturating win/tie tallies.
module baccarat_round_ctrl #(
  parameter int unsigned TALLY_W     = 8,
  parameter int unsigned RESULT_HOLD = 4,
  parameter int unsigned AUTO_RUN    = 0
) (
  input  logic                  slow_clock,
  input  logic                  resetb,
  baccarat_round_ctrl_if.master bus
);

  localparam int unsigned HOLD_W = (RESULT_HOLD > 1) ? $clog2(RESULT_HOLD) : 1;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_DEAL_P1 = 4'd1,
    S_DEAL_D1 = 4'd2,
    S_DEAL_P2 = 4'd3,
    S_DEAL_D2 = 4'd4,
    S_EVAL    = 4'd5,
    S_DEAL_P3 = 4'd6,
    S_EVAL_D  = 4'd7,
    S_DEAL_D3 = 4'd8,
    S_RESULT  = 4'd9
  } state_t;

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               plight_q, plight_d;
  logic               dlight_q, dlight_d;
  logic [TALLY_W-1:0] pwins_q, pwins_d;
  logic [TALLY_W-1:0] dwins_q, dwins_d;
  logic [TALLY_W-1:0] ties_q, ties_d;
  logic               done_q, busy_q;
  logic               ld_p1_q, ld_p2_q, ld_p3_q;
  logic               ld_d1_q, ld_d2_q, ld_d3_q;

  // Banker third-card table, keyed on banker score and the player's third card
  function automatic logic banker_draws(input logic [3:0] d, input logic [3:0] c);
    logic draw;
    draw = 1'b0;
    case (d)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (c != 4'd8);
      4'd4:             draw = (c >= 4'd2) && (c <= 4'd7);
      4'd5:             draw = (c >= 4'd4) && (c <= 4'd7);
      4'd6:             draw = (c >= 4'd6) && (c <= 4'd7);
      default:          draw = 1'b0;
    endcase
    return draw;
  endfunction

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_q  <= S_IDLE;
      hold_q   <= '0;
      plight_q <= 1'b0;
      dlight_q <= 1'b0;
      pwins_q  <= '0;
      dwins_q  <= '0;
      ties_q   <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ld_p1_q  <= 1'b0;
      ld_p2_q  <= 1'b0;
      ld_p3_q  <= 1'b0;
      ld_d1_q  <= 1'b0;
      ld_d2_q  <= 1'b0;
      ld_d3_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      plight_q <= plight_d;
      dlight_q <= dlight_d;
      pwins_q  <= pwins_d;
      dwins_q  <= dwins_d;
      ties_q   <= ties_d;
      done_q   <= (state_d == S_RESULT) && (state_q != S_RESULT);
      busy_q   <= (state_d != S_IDLE);
      ld_p1_q  <= (state_d == S_DEAL_P1);
      ld_d1_q  <= (state_d == S_DEAL_D1);
      ld_p2_q  <= (state_d == S_DEAL_P2);
      ld_d2_q  <= (state_d == S_DEAL_D2);
      ld_p3_q  <= (state_d == S_DEAL_P3);
      ld_d3_q  <= (state_d == S_DEAL_D3);
    end
  end

  // Next state, result latching and tally update; done_q marks the first RESULT cycle
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    plight_d = plight_q;
    dlight_d = dlight_q;
    pwins_d  = pwins_q;
    dwins_d  = dwins_q;
    ties_d   = ties_q;

    case (state_q)
      S_IDLE:    if (bus.start) state_d = S_DEAL_P1;
      S_DEAL_P1: state_d = S_DEAL_D1;
      S_DEAL_D1: state_d = S_DEAL_P2;
      S_DEAL_P2: state_d = S_DEAL_D2;
      S_DEAL_D2: state_d = S_EVAL;
      S_EVAL: begin
        if ((bus.pscore >= 4'd8) || (bus.dscore >= 4'd8)) state_d = S_RESULT;
        else if (bus.pscore <= 4'd5)                      state_d = S_DEAL_P3;
        else if (bus.dscore <= 4'd5)                      state_d = S_DEAL_D3;
        else                                              state_d = S_RESULT;
      end
      S_DEAL_P3: state_d = S_EVAL_D;
      S_EVAL_D:  state_d = banker_draws(bus.dscore, bus.pcard3) ? S_DEAL_D3 : S_RESULT;
      S_DEAL_D3: state_d = S_RESULT;
      S_RESULT: begin
        if (done_q) begin
          hold_d = HOLD_W'(RESULT_HOLD - 1);
          if (bus.pscore > bus.dscore) begin
            plight_d = 1'b1;
            if (pwins_q != {TALLY_W{1'b1}}) pwins_d = pwins_q + TALLY_W'(1);
          end else if (bus.dscore > bus.pscore) begin
            dlight_d = 1'b1;
            if (dwins_q != {TALLY_W{1'b1}}) dwins_d = dwins_q + TALLY_W'(1);
          end else begin
            plight_d = 1'b1;
            dlight_d = 1'b1;
            if (ties_q != {TALLY_W{1'b1}}) ties_d = ties_q + TALLY_W'(1);
          end
          if (RESULT_HOLD <= 1) state_d = (AUTO_RUN != 0) ? S_DEAL_P1 : S_IDLE;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
          if (hold_q <= HOLD_W'(1)) state_d = (AUTO_RUN != 0) ? S_DEAL_P1 : S_IDLE;
        end
      end
      default:   state_d = S_IDLE;
    endcase

    // Every entry into DEAL_P1 starts a fresh round with dark lights
    if ((state_d == S_DEAL_P1) && (state_q != S_DEAL_P1)) begin
      plight_d = 1'b0;
      dlight_d = 1'b0;
    end
  end

  assign bus.load_pcard1      = ld_p1_q;
  assign bus.load_pcard2      = ld_p2_q;
  assign bus.load_pcard3      = ld_p3_q;
  assign bus.load_dcard1      = ld_d1_q;
  assign bus.load_dcard2      = ld_d2_q;
  assign bus.load_dcard3      = ld_d3_q;
  assign bus.player_win_light = plight_q;
  assign bus.dealer_win_light = dlight_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.player_wins      = pwins_q;
  assign bus.dealer_wins      = dwins_q;
  assign bus.ties             = ties_q;

endmodule

// File: tb/tb_baccarat_round_ctrl.sv
// Randomized and directed rounds for baccarat_round_ctrl, checked against a
// rule-level punto-banco model with a simple card-register datapath around the DUT.
module tb_baccarat_round_ctrl;

  localparam int unsigned TALLY_W     = 2;
  localparam int unsigned RESULT_HOLD = 4;
  localparam int          TALLY_MAX   = 3;

  logic slow_clock = 1'b0;
  logic resetb;

  always #5 slow_clock = ~slow_clock;

  baccarat_round_ctrl_if #(.TALLY_W(TALLY_W)) bus ();

  baccarat_round_ctrl #(
    .TALLY_W     (TALLY_W),
    .RESULT_HOLD (RESULT_HOLD),
    .AUTO_RUN    (0)
  ) dut (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .bus        (bus.master)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Card datapath: card order P1 D1 P2 D2 P3 D3 maps to cards[0..5]
  int cards [6];
  logic [3:0] pc1, pc2, pc3, dc1, dc2, dc3;

  always @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      pc1 <= '0; pc2 <= '0; pc3 <= '0;
      dc1 <= '0; dc2 <= '0; dc3 <= '0;
    end else begin
      if (bus.load_pcard1) begin pc1 <= 4'(cards[0]); pc2 <= '0; pc3 <= '0; end
      if (bus.load_dcard1) begin dc1 <= 4'(cards[1]); dc2 <= '0; dc3 <= '0; end
      if (bus.load_pcard2) pc2 <= 4'(cards[2]);
      if (bus.load_dcard2) dc2 <= 4'(cards[3]);
      if (bus.load_pcard3) pc3 <= 4'(cards[4]);
      if (bus.load_dcard3) dc3 <= 4'(cards[5]);
    end
  end

  assign bus.pscore = 4'((int'(pc1) + int'(pc2) + int'(pc3)) % 10);
  assign bus.dscore = 4'((int'(dc1) + int'(dc2) + int'(dc3)) % 10);
  assign bus.pcard3 = pc3;

  // Banker draw sets: bit k set means draw when the player's third card is k
  logic [9:0] bank_mask [8];
  initial begin
    bank_mask[0] = 10'h3FF; bank_mask[1] = 10'h3FF; bank_mask[2] = 10'h3FF;
    bank_mask[3] = 10'h2FF; bank_mask[4] = 10'h0FC; bank_mask[5] = 10'h0F0;
    bank_mask[6] = 10'h0C0; bank_mask[7] = 10'h000;
  end

  int m_pw, m_dw, m_ties;
  int exp_cyc [6];
  int exp_done, exp_lights;

  function automatic int sat_inc(input int v);
    return (v < TALLY_MAX) ? v + 1 : v;
  endfunction

  // Plays the hand by the rules and predicts strobe timing, lights and tallies
  task automatic model_round();
    int p, d, pf, df;
    bit nat, pdraw, bdraw;
    p     = (cards[0] + cards[2]) % 10;
    d     = (cards[1] + cards[3]) % 10;
    nat   = (p >= 8) || (d >= 8);
    pdraw = !nat && (p <= 5);
    if (pdraw) bdraw = bank_mask[d][cards[4]];
    else       bdraw = !nat && (d <= 5);
    pf = pdraw ? (p + cards[4]) % 10 : p;
    df = bdraw ? (d + cards[5]) % 10 : d;
    exp_cyc[0] = 1; exp_cyc[1] = 2; exp_cyc[2] = 3; exp_cyc[3] = 4;
    exp_cyc[4] = pdraw ? 6 : 0;
    exp_cyc[5] = bdraw ? (pdraw ? 8 : 6) : 0;
    exp_done   = 6 + (pdraw ? 2 : 0) + (bdraw ? 1 : 0);
    if (pf > df)      begin exp_lights = 2; m_pw   = sat_inc(m_pw);   end
    else if (df > pf) begin exp_lights = 1; m_dw   = sat_inc(m_dw);   end
    else              begin exp_lights = 3; m_ties = sat_inc(m_ties); end
  endtask

  task automatic do_reset();
    bus.start = 1'b0;
    resetb    = 1'b0;
    repeat (2) @(negedge slow_clock);
    resetb = 1'b1;
    m_pw = 0; m_dw = 0; m_ties = 0;
    @(negedge slow_clock);
    check("rst_busy",   int'(bus.busy), 0);
    check("rst_done",   int'(bus.done), 0);
    check("rst_lights", int'({bus.player_win_light, bus.dealer_win_light}), 0);
    check("rst_tally",  int'(bus.player_wins) + int'(bus.dealer_wins) + int'(bus.ties), 0);
  endtask

  function automatic int strobe_vec();
    return int'({bus.load_dcard3, bus.load_pcard3, bus.load_dcard2,
                 bus.load_pcard2, bus.load_dcard1, bus.load_pcard1});
  endfunction

  task automatic run_round(input int c0, input int c1, input int c2,
                           input int c3, input int c4, input int c5);
    int got_cyc [6];
    int done_cyc, done_cnt, multi, idle_cyc, lights_c1, sv;
    cards[0] = c0; cards[1] = c1; cards[2] = c2;
    cards[3] = c3; cards[4] = c4; cards[5] = c5;
    model_round();
    foreach (got_cyc[i]) got_cyc[i] = 0;
    done_cyc = 0; done_cnt = 0; multi = 0; idle_cyc = 0; lights_c1 = -1;
    bus.start = 1'b1;
    for (int cyc = 1; cyc <= 40 && idle_cyc == 0; cyc++) begin
      @(negedge slow_clock);
      if (cyc == 1) begin
        bus.start = 1'b0;
        lights_c1 = int'({bus.player_win_light, bus.dealer_win_light});
      end
      sv = strobe_vec();
      if ($countones(sv) > 1) multi++;
      for (int i = 0; i < 6; i++)
        if (sv[i] && got_cyc[i] == 0) got_cyc[i] = cyc;
      if (bus.done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (!bus.busy) idle_cyc = cyc;
    end
    check("strobe_p1", got_cyc[0], exp_cyc[0]);
    check("strobe_d1", got_cyc[1], exp_cyc[1]);
    check("strobe_p2", got_cyc[2], exp_cyc[2]);
    check("strobe_d2", got_cyc[3], exp_cyc[3]);
    check("strobe_p3", got_cyc[4], exp_cyc[4]);
    check("strobe_d3", got_cyc[5], exp_cyc[5]);
    check("one_strobe", multi, 0);
    check("done_cycle", done_cyc, exp_done);
    check("done_width", done_cnt, 1);
    check("idle_cycle", idle_cyc, exp_done + int'(RESULT_HOLD));
    check("lights_clr", lights_c1, 0);
    check("lights", int'({bus.player_win_light, bus.dealer_win_light}), exp_lights);
    check("player_wins", int'(bus.player_wins), m_pw);
    check("dealer_wins", int'(bus.dealer_wins), m_dw);
    check("ties", int'(bus.ties), m_ties);
  endtask

  initial begin
    int hits, seen;
    bus.start = 1'b0;
    resetb    = 1'b1;
    foreach (cards[i]) cards[i] = 0;
    #2;
    do_reset();

    // Natural 8 vs 3, then player 6 stands and banker 4 draws to 9
    run_round(4, 1, 4, 2, 0, 0);
    run_round(3, 2, 3, 2, 0, 5);

    // Banker table sweep with player on 2
    for (int d = 0; d < 8; d++)
      for (int p3 = 0; p3 < 10; p3++)
        run_round(1, 0, 1, d, p3, int'($urandom_range(0, 9)));

    // Tie 5-5 with RESULT hold; lights persist through IDLE
    do_reset();
    run_round(1, 2, 1, 3, 3, 0);
    repeat (3) @(negedge slow_clock);
    check("tie_hold_lights", int'({bus.player_win_light, bus.dealer_win_light}), 3);
    check("tie_idle_busy", int'(bus.busy), 0);

    // Tally saturation
    do_reset();
    for (int i = 0; i < 5; i++) run_round(4, 0, 5, 0, 0, 0);
    check("sat_player", int'(bus.player_wins), TALLY_MAX);
    check("sat_others", int'(bus.dealer_wins) + int'(bus.ties), 0);

    // Random rounds
    for (int r = 0; r < 150; r++) begin
      if (r % 30 == 0) do_reset();
      run_round(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
    end

    // Asynchronous reset while in DEAL_P3
    do_reset();
    cards[0] = 1; cards[1] = 0; cards[2] = 1; cards[3] = 3; cards[4] = 4; cards[5] = 4;
    bus.start = 1'b1;
    hits = 0;
    for (int cyc = 1; cyc <= 20 && hits == 0; cyc++) begin
      @(negedge slow_clock);
      bus.start = 1'b0;
      if (bus.load_pcard3) hits = cyc;
    end
    check("p3_reached", hits, 6);
    #2 resetb = 1'b0;
    #1;
    check("arst_strobes", strobe_vec(), 0);
    check("arst_busy", int'(bus.busy), 0);
    check("arst_done", int'(bus.done), 0);
    check("arst_lights", int'({bus.player_win_light, bus.dealer_win_light}), 0);
    check("arst_tally", int'(bus.player_wins) + int'(bus.dealer_wins) + int'(bus.ties), 0);
    @(negedge slow_clock);
    resetb = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge slow_clock);
      if (bus.busy || strobe_vec() != 0) seen++;
    end
    check("arst_stay_idle", seen, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/baccarat_round_ctrl.md
Name: baccarat_round_ctrl

Overview:
Second-generation baccarat dealing controller that replaces the fixed six-card sequencer. It applies full punto-banco drawing rules: naturals, the player third-card rule, and the banker third-card table keyed on pcard3. It latches result lights and keeps saturating win/tie tallies. It sits between the card datapath (score and card registers) and the board LEDs/HEX, driven by the debounced slow clock.

Parameters:
TALLY_W, 8, width of each win/tie tally counter; counters saturate at all-ones.
RESULT_HOLD, 4, slow_clock cycles spent in RESULT before the FSM leaves it; must be ≥1.
AUTO_RUN, 0, 1 = return from RESULT directly to DEAL_P1 (continuous play); 0 = return to IDLE and wait for start.

Ports:
slow_clock  in  1  single clock; all state changes on its rising edge.
resetb  in  1  asynchronous, active-low reset.
start  in  1  level; sampled in IDLE only; 1 begins a round.
pscore  in  4  player hand score 0–9, valid the cycle after any load.
dscore  in  4  banker hand score 0–9, same timing.
pcard3  in  4  player third card value 0–9 (0 for 10/J/Q/K), valid the cycle after load_pcard3.
load_pcard1, load_pcard2, load_pcard3  out  1 each  one-cycle load strobes for the player card registers.
load_dcard1, load_dcard2, load_dcard3  out  1 each  one-cycle load strobes for the banker card registers.
player_win_light  out  1  registered; 1 = player won, or tie.
dealer_win_light  out  1  registered; 1 = banker won, or tie.
busy  out  1  1 in every state except IDLE.
done  out  1  one-cycle pulse on the first RESULT cycle.
player_wins, dealer_wins, ties  out  TALLY_W each  saturating round tallies.

Behaviour:
- Reset (async, resetb=0): state=IDLE; all load strobes=0; both lights=0; done=0; busy=0; all tallies=0; hold counter=0. Reset asserted mid-round aborts immediately. Tallies are not updated for the aborted round.
- Load strobes are Moore outputs of their DEAL state, exactly one cycle long. At most one strobe is high in any cycle.
- States:
  - IDLE: if start=1, go to DEAL_P1 and clear both lights.
  - DEAL_P1 → DEAL_D1 → DEAL_P2 → DEAL_D2 → EVAL, one cycle each.
  - EVAL (scores of 4 cards valid):
    - pscore≥8 or dscore≥8 → RESULT (natural, no draws).
    - else pscore≤5 → DEAL_P3.
    - else (player stands on 6/7): dscore≤5 → DEAL_D3, otherwise → RESULT.
  - DEAL_P3 → EVAL_D.
  - EVAL_D (pcard3 valid): banker draws (→ DEAL_D3) when any of these holds, otherwise → RESULT:
    - dscore≤2
    - dscore=3 and pcard3≠8
    - dscore=4 and pcard3∈2..7
    - dscore=5 and pcard3∈4..7
    - dscore=6 and pcard3∈6..7
    - dscore=7 never draws.
  - DEAL_D3 → RESULT.
  - RESULT:
    - First cycle: compare pscore and dscore. pscore>dscore → player_win_light=1 and player_wins+1. dscore>pscore → dealer_win_light=1 and dealer_wins+1. Equal → both lights=1 and ties+1. Assert done. Load hold counter with RESULT_HOLD−1.
    - Later cycles: decrement the hold counter. When it reaches 0, exit to DEAL_P1 if AUTO_RUN=1, else to IDLE.
  - Illegal state encodings → IDLE.
- Lights hold their value through IDLE until the next round starts (the DEAL_P1 entry clears them) or reset.
- Tallies increment exactly once per completed round. At 2^TALLY_W−1 a tally holds its value; the other tallies are unaffected.
- start is ignored outside IDLE; holding start high in IDLE gives back-to-back rounds.
- Round latency from IDLE with start=1: minimum 6 cycles to RESULT (natural); maximum 9 cycles (both third cards).

Test Plan:
- Natural: pscore=8, dscore=3 at EVAL → no P3/D3 strobes; RESULT 6 cycles after start; player_win_light=1, dealer=0, player_wins=1, done pulse of 1 cycle.
- Player stands, banker draws: pscore=6, dscore=4 → load_dcard3 only. Then final pscore=6, dscore=9 → dealer_win_light=1, dealer_wins=1.
- Banker table sweep: pscore=2, pcard3=8, dscore=3 → banker stands. Repeat with pcard3=7, dscore=6 → banker draws. Check all 8×10 dscore/pcard3 combinations against the table.
- Tie plus hold: final pscore=dscore=5 and RESULT_HOLD=4 → both lights=1, ties=1. FSM in RESULT for exactly 4 cycles, then IDLE (AUTO_RUN=0). Lights stay 1 in IDLE until the next start.
- Saturation: TALLY_W=2 with 5 player wins → player_wins sticks at 3; dealer_wins and ties stay 0.
- Async reset mid-round: deassert resetb between clock edges during DEAL_P3 → all outputs 0 immediately and tallies unchanged from before the round. After release, the FSM stays in IDLE while start=0.
